// File: rtl/field_addsub_seq.sv
// Sequential modular add/subtract over the secp256k1 base field.
// One shared LIMB_W-bit adder is used for two passes of 256/LIMB_W limbs each:
//   pass 1: s = a + b        (op=0)  or  s = a - b        (op=1)
//   pass 2: t = s - p        (op=0)  or  t = s + p        (op=1)
// The final result is chosen from s or t using the pass carries.
// Ports:
//   clk     - clock, rising edge
//   reset_n - asynchronous active-low reset
//   start   - request pulse, sampled only while idle
//   op      - 0: (a+b) mod p, 1: (a-b) mod p
//   a, b    - 256-bit operands, expected < p
//   busy    - high while an operation is in flight (including the done cycle)
//   done    - one-cycle pulse; result valid from this cycle
//   result  - registered field result, held between operations
module field_addsub_seq #(
  parameter int unsigned LIMB_W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         op,
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic         busy,
  output logic         done,
  output logic [255:0] result
);

  localparam int unsigned NLimbs = 256 / LIMB_W;
  localparam logic [255:0] P =
    256'hffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_fffffffe_fffffc2f;

  typedef enum logic [1:0] {StIdle, StPass1, StPass2, StDone} state_e;

  state_e         state_q;
  logic [1:0]     cnt_q;
  logic           carry_q;
  logic           c1_q, c2_q, c2_d;
  logic           op_q;
  logic [255:0]   a_q, b_q, s_q, t_q;
  logic [255:0]   result_q;
  logic           busy_q, done_q;
  // Blocks start on the first edge after reset release.
  logic           armed_q;

  int unsigned    lsb;
  logic           last_limb;
  logic [LIMB_W-1:0] x, y;
  logic           cin;
  logic [LIMB_W:0]   sum_w;
  logic [255:0]   t_full;
  logic [255:0]   res_sel;

  assign lsb       = int'(cnt_q) * LIMB_W;
  assign last_limb = (cnt_q == 2'(NLimbs - 1));

  always_comb begin
    x   = '0;
    y   = '0;
    cin = 1'b0;
    if (state_q == StPass2) begin
      x   = s_q[lsb +: LIMB_W];
      y   = op_q ? P[lsb +: LIMB_W] : ~P[lsb +: LIMB_W];
      cin = (cnt_q == 2'd0) ? ~op_q : carry_q;
    end else begin
      x   = a_q[lsb +: LIMB_W];
      y   = op_q ? ~b_q[lsb +: LIMB_W] : b_q[lsb +: LIMB_W];
      cin = (cnt_q == 2'd0) ? op_q : carry_q;
    end
    sum_w = {1'b0, x} + {1'b0, y} + {{LIMB_W{1'b0}}, cin};
  end

  // Final-cycle view of t: the top limb is still on the adder output.
  always_comb begin
    t_full = t_q;
    t_full[lsb +: LIMB_W] = sum_w[LIMB_W-1:0];
    c2_d = c2_q;
    if (state_q == StPass2 && last_limb) begin
      c2_d = ~op_q & sum_w[LIMB_W];
    end
    // Subtraction: carry out of pass 1 means no borrow, so s is already reduced.
    if (op_q) begin
      res_sel = c1_q ? s_q : t_full;
    end else begin
      res_sel = (c1_q | c2_d) ? t_full : s_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= 2'd0;
      carry_q  <= 1'b0;
      c1_q     <= 1'b0;
      c2_q     <= 1'b0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      t_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start && armed_q) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StPass1;
          end
        end
        StPass1: begin
          s_q[lsb +: LIMB_W] <= sum_w[LIMB_W-1:0];
          carry_q            <= sum_w[LIMB_W];
          cnt_q              <= cnt_q + 2'd1;
          if (last_limb) begin
            c1_q    <= sum_w[LIMB_W];
            state_q <= StPass2;
          end
        end
        StPass2: begin
          t_q[lsb +: LIMB_W] <= sum_w[LIMB_W-1:0];
          carry_q            <= sum_w[LIMB_W];
          cnt_q              <= cnt_q + 2'd1;
          c2_q               <= c2_d;
          if (last_limb) begin
            result_q <= res_sel;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_field_addsub_seq.sv
// Self-checking bench for field_addsub_seq: scoreboard queue of expected
// results filled at acceptance and drained on each done pulse.
module tb_field_addsub_seq;

  localparam logic [255:0] P =
    256'hffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_fffffffe_fffffc2f;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic         op_i;
  logic [255:0] a_i, b_i;
  logic         busy, done;
  logic [255:0] result;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int cyc      = 0;
  logic [255:0] exp_q[$];

  field_addsub_seq #(.LIMB_W(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op_i),
    .a       (a_i),
    .b       (b_i),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [255:0] model(input logic o, input logic [255:0] x,
                                         input logic [255:0] y);
    logic [256:0] w;
    if (!o) begin
      w = {1'b0, x} + {1'b0, y};
      if (w >= {1'b0, P}) w = w - {1'b0, P};
    end else if (x >= y) begin
      w = {1'b0, x - y};
    end else begin
      w = {1'b0, x} + {1'b0, P} - {1'b0, y};
    end
    return w[255:0];
  endfunction

  function automatic logic [255:0] rand_fe();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    v[255] = 1'b0;
    return v;
  endfunction

  // Scoreboard drain.
  always @(negedge clk) begin
    if (reset_n && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check_val("spurious_done", 256'(done), 256'd0);
      end else begin
        check_val("result", result, exp_q.pop_front());
      end
    end
  end

  // One operation. pulse_k: drive a stray start at that busy cycle.
  // abort_k: assert reset at that busy cycle and return with reset held.
  task automatic run_op(input logic o, input logic [255:0] x, input logic [255:0] y,
                        input int pulse_k, input int abort_k);
    int acc;
    int k;
    logic [255:0] e;
    @(negedge clk);
    start = 1'b1; op_i = o; a_i = x; b_i = y;
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
    e = model(o, x, y);
    exp_q.push_back(e);
    op_i = ~o; a_i = rand_fe(); b_i = rand_fe();
    k = 0;
    while (!done && k < 20) begin
      check_val("busy_high", 256'(busy), 256'd1);
      if (k == abort_k) begin
        reset_n = 1'b0;
        #1;
        check_val("abort_busy", 256'(busy), 256'd0);
        check_val("abort_done", 256'(done), 256'd0);
        check_val("abort_result", result, 256'd0);
        exp_q.delete();
        return;
      end
      start = (k == pulse_k);
      if (k == pulse_k) begin
        op_i = ~o; a_i = rand_fe(); b_i = rand_fe();
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check_val("done_seen", 256'(done), 256'd1);
    check_val("latency", 256'(cyc - acc), 256'd8);
    check_val("busy_at_done", 256'(busy), 256'd1);
    @(negedge clk);
    check_val("done_one_cycle", 256'(done), 256'd0);
    check_val("busy_idle", 256'(busy), 256'd0);
    check_val("result_hold", result, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int prev_done;
    int k;
    logic         bo;
    logic [255:0] bx, by;

    reset_n = 1'b0; start = 1'b1; op_i = 1'b0; a_i = 256'd1; b_i = 256'd2;
    #1;
    check_val("rst_busy", 256'(busy), 256'd0);
    check_val("rst_done", 256'(done), 256'd0);
    check_val("rst_result", result, 256'd0);
    repeat (2) @(negedge clk);
    // Release coincident with a rising edge while start is high.
    @(posedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("start_on_release", 256'(busy), 256'd0);
    start = 1'b0;

    run_op(1'b0, 256'd1, 256'd2, -1, -1);
    run_op(1'b0, P - 256'd1, 256'd1, -1, -1);
    run_op(1'b0, P - 256'd1, P - 256'd1, -1, -1);
    run_op(1'b1, 256'd5, 256'd3, -1, -1);
    run_op(1'b1, 256'd0, 256'd1, -1, -1);
    for (int i = 0; i < 3; i++) run_op(1'(i), rand_fe(), rand_fe(), -1, -1);

    // Stray start during busy: one done only, original operands.
    d0 = n_done;
    run_op(1'b0, rand_fe(), rand_fe(), 2, -1);
    repeat (12) @(negedge clk);
    check_val("one_done_only", 256'(n_done - d0), 256'd1);
    check_val("no_queued_op", 256'(busy), 256'd0);

    // Reset mid-operation.
    d0 = n_done;
    run_op(1'b0, rand_fe(), rand_fe(), -1, 4);
    repeat (3) @(negedge clk);
    check_val("abort_no_done", 256'(n_done - d0), 256'd0);
    reset_n = 1'b1;
    run_op(1'b0, 256'd7, 256'd8, -1, -1);

    // Back-to-back with start held high.
    prev_done = 0;
    @(negedge clk);
    start = 1'b1;
    bo = 1'b1; bx = P - 256'd1; by = P - 256'd1;
    op_i = bo; a_i = bx; b_i = by;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_q.push_back(model(bo, bx, by));
      op_i = ~bo; a_i = rand_fe(); b_i = rand_fe();
      k = 0;
      while (!done && k < 20) begin
        @(negedge clk);
        k++;
      end
      check_val("b2b_done_seen", 256'(done), 256'd1);
      if (i > 0) check_val("b2b_period", 256'(cyc - prev_done), 256'd10);
      prev_done = cyc;
      @(negedge clk);
      bo = 1'($urandom_range(1)); bx = rand_fe(); by = rand_fe();
      op_i = bo; a_i = bx; b_i = by;
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    check_val("scoreboard_empty", 256'(exp_q.size()), 256'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
